// File: rtl/uart_rx_multi.sv
// uart_rx_multi: x16-oversampling UART receiver with a per-character status FIFO (first-word-fall-through).
// Define UART_RX_PARITY_EN to build the parity state and the par_err FIFO bit; otherwise frames are DATA_BITS N 1.
module uart_rx_multi #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk_rx,
  input  logic                                 rst_clk_rx_n,
  input  logic                                 rxd_i,
  input  logic                                 read_en,
  input  logic                                 clear_lost,
  output logic                                 rxd_clk_rx,
  output logic [DATA_BITS-1:0]                 rx_data,
  output logic                                 rx_data_rdy,
  output logic                                 frm_err,
  output logic                                 par_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 lost_data
);

  localparam int DIV   = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != 0);
  localparam int ENTRY_W = DATA_BITS + 2;
`else
  localparam int ENTRY_W = DATA_BITS + 1;
`endif

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_multi: baud divider DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_multi: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_multi: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_multi: FIFO_DEPTH must be a power of two >= 2");
  end

  // Reset bridge: assert immediately, release on a clk_rx edge.
  logic rst_meta_n, rst_int_n;
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) {rst_int_n, rst_meta_n} <= 2'b00;
    else               {rst_int_n, rst_meta_n} <= {rst_meta_n, 1'b1};
  end

  logic rxd_meta;
  always_ff @(posedge clk_rx or negedge rst_int_n) begin
    if (!rst_int_n) {rxd_clk_rx, rxd_meta} <= 2'b11;
    else            {rxd_clk_rx, rxd_meta} <= {rxd_meta, rxd_i};
  end

  logic [DIV_W-1:0] baud_cnt;
  logic             baud_en;
  assign baud_en = (baud_cnt == '0);
  always_ff @(posedge clk_rx or negedge rst_int_n) begin
    if (!rst_int_n)   baud_cnt <= '0;
    else if (baud_en) baud_cnt <= DIV_W'(DIV - 1);
    else              baud_cnt <= baud_cnt - DIV_W'(1);
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push;
  logic                 push_frm;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk_rx or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      push     <= 1'b0;
      push_frm <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
          if (!rxd_clk_rx) state <= START;
        end
        START: if (baud_en) begin
          if (tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            state    <= rxd_clk_rx ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        // tick_cnt wraps 15 -> 0, so each sample lands 16 ticks after the previous one.
        DATA: if (baud_en) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shreg   <= {rxd_clk_rx, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PAR_ON ? PAR : STOP;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PAR: if (baud_en) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_bad <= ((^shreg) ^ rxd_clk_rx) != (PARITY == 2);
            state   <= STOP;
          end
        end
`endif
        STOP: if (baud_en) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            push     <= 1'b1;
            push_frm <= ~rxd_clk_rx;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] push_entry, head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               empty, full, pop, wr;

`ifdef UART_RX_PARITY_EN
  assign push_entry = {par_bad, push_frm, shreg};
`else
  assign push_entry = {push_frm, shreg};
`endif
  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop   = read_en && !empty;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk_rx or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lost_data  <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) lost_data <= 1'b1;
      else if (clear_lost)      lost_data <= 1'b0;
    end
  end

  // Storage is not reset; the head outputs are gated by empty instead.
  always_ff @(posedge clk_rx) begin
    if (wr) mem[wr_ptr] <= push_entry;
  end

  assign head        = mem[rd_ptr];
  assign rx_data_rdy = !empty;
  assign rx_data     = empty ? '0 : head[DATA_BITS-1:0];
  assign frm_err     = !empty && head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign par_err     = !empty && head[DATA_BITS+1];
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed bench for uart_rx_multi: table of 8N1 frames plus hand sequences for latency,
// false start, overflow, full push/pop, reset mid-frame and 7-bit/parity framing.
module tb_uart_rx_multi;

  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 390_625;
  localparam int DIV        = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int BIT        = 16 * DIV;

  logic       clk_rx = 1'b0;
  logic       rst_clk_rx_n = 1'b0;
  logic       rxd_i = 1'b1, read_en = 1'b0, clear_lost = 1'b0;
  logic       rxd_clk_rx, rx_data_rdy, frm_err, par_err, lost_data;
  logic [7:0] rx_data;
  logic [2:0] fifo_count;

  logic       rxd_p = 1'b1, read_en_p = 1'b0, clear_lost_p = 1'b0;
  logic       rxd_clk_rx_p, rx_data_rdy_p, frm_err_p, par_err_p, lost_data_p;
  logic [6:0] rx_data_p;
  logic [2:0] fifo_count_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_rx = ~clk_rx;

  uart_rx_multi #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                  .PARITY(0), .FIFO_DEPTH(4)) dut (
    .clk_rx(clk_rx), .rst_clk_rx_n(rst_clk_rx_n), .rxd_i(rxd_i), .read_en(read_en),
    .clear_lost(clear_lost), .rxd_clk_rx(rxd_clk_rx), .rx_data(rx_data),
    .rx_data_rdy(rx_data_rdy), .frm_err(frm_err), .par_err(par_err),
    .fifo_count(fifo_count), .lost_data(lost_data));

  uart_rx_multi #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
                  .PARITY(1), .FIFO_DEPTH(4)) dut_p (
    .clk_rx(clk_rx), .rst_clk_rx_n(rst_clk_rx_n), .rxd_i(rxd_p), .read_en(read_en_p),
    .clear_lost(clear_lost_p), .rxd_clk_rx(rxd_clk_rx_p), .rx_data(rx_data_p),
    .rx_data_rdy(rx_data_rdy_p), .frm_err(frm_err_p), .par_err(par_err_p),
    .fifo_count(fifo_count_p), .lost_data(lost_data_p));

  typedef struct {
    logic [7:0] data;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_frm;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else     rxd_i = v;
  endtask

  // A low stop bit is held for 3/4 bit so the restart it causes is a clean false start.
  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input bit has_par, input bit pbit, input bit stop);
    @(negedge clk_rx);
    drive(sel, 1'b0);
    repeat (BIT) @(negedge clk_rx);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      repeat (BIT) @(negedge clk_rx);
    end
    if (has_par) begin
      drive(sel, pbit);
      repeat (BIT) @(negedge clk_rx);
    end
    drive(sel, stop);
    repeat (stop ? BIT : (BIT * 3) / 4) @(negedge clk_rx);
    drive(sel, 1'b1);
    repeat (BIT) @(negedge clk_rx);
  endtask

  task automatic pop_one();
    read_en = 1'b1;
    @(negedge clk_rx);
    read_en = 1'b0;
  endtask

  task automatic pop_p();
    read_en_p = 1'b1;
    @(negedge clk_rx);
    read_en_p = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    bit   seen;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_frm: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_frm: 1'b1};
    vecs[2] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_frm: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_frm: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_frm: 1'b0};
    vecs[5] = '{data: 8'h80, stop: 1'b0, exp_data: 8'h80, exp_frm: 1'b1};

    repeat (3) @(negedge clk_rx);
    check("rst_rxd_clk_rx", rxd_clk_rx, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rdy", rx_data_rdy, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_par_err", par_err, 0);
    check("rst_count", fifo_count, 0);
    check("rst_lost", lost_data, 0);
    rst_clk_rx_n = 1'b1;
    repeat (5) @(negedge clk_rx);

    lat = 0;
    fork
      send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
      begin
        @(negedge rxd_i);
        while (!rx_data_rdy && lat < 4 * BIT * 10) begin
          @(posedge clk_rx);
          lat++;
          @(negedge clk_rx);
        end
      end
    join
    check("latency_low", (lat >= 151 * DIV) ? 1 : 0, 1);
    check("latency_high", (lat <= 152 * DIV + 4) ? 1 : 0, 1);
    check("lat_data", rx_data, 8'hA5);
    check("lat_count", fifo_count, 1);
    pop_one();
    check("lat_pop_rdy", rx_data_rdy, 0);
    check("lat_pop_count", fifo_count, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, {1'b0, vecs[i].data}, 8, 1'b0, 1'b0, vecs[i].stop);
      check($sformatf("vec%0d_count", i), fifo_count, 1);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_frm", i), frm_err, vecs[i].exp_frm);
      check($sformatf("vec%0d_par", i), par_err, 0);
      pop_one();
      check($sformatf("vec%0d_empty", i), fifo_count, 0);
    end

    @(negedge clk_rx);
    rxd_i = 1'b0;
    repeat (4 * DIV) @(negedge clk_rx);
    rxd_i = 1'b1;
    repeat (2 * BIT) @(negedge clk_rx);
    check("false_start_count", fifo_count, 0);
    check("false_start_rdy", rx_data_rdy, 0);

    for (int v = 1; v <= 5; v++) send_frame(1'b0, 9'(v), 8, 1'b0, 1'b0, 1'b1);
    check("ovf_count", fifo_count, 4);
    check("ovf_lost", lost_data, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_pop%0d", k), rx_data, k);
      pop_one();
    end
    check("ovf_drained", fifo_count, 0);
    check("ovf_lost_sticky", lost_data, 1);
    clear_lost = 1'b1;
    @(negedge clk_rx);
    clear_lost = 1'b0;
    check("lost_cleared", lost_data, 0);

    for (int v = 'h10; v <= 'h13; v++) send_frame(1'b0, 9'(v), 8, 1'b0, 1'b0, 1'b1);
    check("full_count", fifo_count, 4);
    seen = 1'b0;
    fork
      send_frame(1'b0, 9'h014, 8, 1'b0, 1'b0, 1'b1);
      begin
        for (int c = 0; c < 12 * BIT && !seen; c++) begin
          @(negedge clk_rx);
          if (dut.push) seen = 1'b1;
        end
        if (seen) begin
          read_en = 1'b1;
          @(negedge clk_rx);
          read_en = 1'b0;
        end
      end
    join
    check("full_push_seen", seen, 1);
    check("full_pushpop_count", fifo_count, 4);
    check("full_pushpop_lost", lost_data, 0);
    for (int k = 'h11; k <= 'h14; k++) begin
      check($sformatf("full_pop_%0h", k), rx_data, k);
      pop_one();
    end

    send_frame(1'b0, 9'h021, 8, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 9'h042, 8, 1'b0, 1'b0, 1'b1);
    check("pre_rst_count", fifo_count, 2);
    rxd_i = 1'b0;
    repeat (BIT) @(negedge clk_rx);
    rxd_i = 1'b1;
    repeat (BIT) @(negedge clk_rx);
    rxd_i = 1'b0;
    repeat (BIT) @(negedge clk_rx);
    repeat (BIT / 2) @(negedge clk_rx);
    check("pre_rst_rxd_sync", rxd_clk_rx, 0);
    rst_clk_rx_n = 1'b0;
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_rdy", rx_data_rdy, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_rxd_sync", rxd_clk_rx, 1);
    rxd_i = 1'b1;
    repeat (3) @(negedge clk_rx);
    rst_clk_rx_n = 1'b1;
    repeat (4) @(negedge clk_rx);
    check("post_rst_count", fifo_count, 0);
    send_frame(1'b0, 9'h07E, 8, 1'b0, 1'b0, 1'b1);
    check("post_rst_7e_count", fifo_count, 1);
    check("post_rst_7e_data", rx_data, 8'h7E);
    check("post_rst_7e_frm", frm_err, 0);
    pop_one();

`ifdef UART_RX_PARITY_EN
    send_frame(1'b1, 9'h001, 7, 1'b1, 1'b0, 1'b1);
    check("par_bad_count", fifo_count_p, 1);
    check("par_bad_data", rx_data_p, 7'h01);
    check("par_bad_flag", par_err_p, 1);
    check("par_bad_frm", frm_err_p, 0);
    pop_p();
    send_frame(1'b1, 9'h001, 7, 1'b1, 1'b1, 1'b1);
    check("par_ok_data", rx_data_p, 7'h01);
    check("par_ok_flag", par_err_p, 0);
    check("par_ok_frm", frm_err_p, 0);
    pop_p();
`else
    send_frame(1'b1, 9'h001, 7, 1'b0, 1'b0, 1'b1);
    check("b7_count", fifo_count_p, 1);
    check("b7_data", rx_data_p, 7'h01);
    check("b7_par", par_err_p, 0);
    check("b7_frm", frm_err_p, 0);
    pop_p();
`endif
    check("p_empty", fifo_count_p, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver: successor to the fixed 8N1 receiver, with configurable data width, parity mode and receive-FIFO depth. Contains:
- the rxd pin synchroniser;
- the x16 baud-enable generator;
- the frame state machine;
- a per-character status FIFO.

It sits between the board RXD pad and the command parser, which drains characters with a read strobe. Each FIFO entry carries its own framing and parity error flags.

## Interface
- CLOCK_RATE, 50_000_000, clk_rx frequency in Hz
- BAUD_RATE, 115_200, line rate in bit/s
- DATA_BITS, 8, data bits per character, legal 5..9, LSB first on the line
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd; effective only with UART_RX_PARITY_EN
- FIFO_DEPTH, 16, receive FIFO entries, power of two, ≥2
- clk_rx  in  1  system clock
- rst_clk_rx_n  in  1  reset, asynchronous assert, active-low
- rxd_i  in  1  RXD pad, asynchronous
- read_en  in  1  pop head FIFO entry; ignored when empty
- clear_lost  in  1  clears lost_data
- rxd_clk_rx  out  1  rxd_i after 2-flop synchroniser
- rx_data  out  DATA_BITS  head entry data, valid while rx_data_rdy=1
- rx_data_rdy  out  1  FIFO non-empty
- frm_err  out  1  head entry stop bit sampled 0
- par_err  out  1  head entry parity mismatch
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held
- lost_data  out  1  sticky: a character arrived while FIFO full

## Operation
- Reset values: rxd_clk_rx=1 (synchroniser flops preset), rx_data=0, rx_data_rdy=0, frm_err=0, par_err=0, fifo_count=0, lost_data=0; FSM in IDLE; baud counter cleared.
- Baud generator:
  - DIV = (CLOCK_RATE + 8*BAUD_RATE) / (16*BAUD_RATE), i.e. rounded.
  - A free-running counter counts DIV-1 down to 0; baud_x16_en pulses for one clk_rx when it reaches 0, then reloads.
  - Elaboration error if DIV < 2.
- FSM states:
  - IDLE → START when rxd_clk_rx=0; tick counter cleared.
  - START: at the 8th tick, rxd=0 → DATA; rxd=1 → IDLE (false start, nothing written).
  - DATA: samples one bit every 16 ticks, LSB first, into a shift register; after DATA_BITS samples goes to PARITY if parity is enabled and PARITY≠0, else STOP.
  - PARITY: samples one bit after 16 ticks, then goes to STOP. Error if XOR(data, bit) ≠ (PARITY==2).
  - STOP: samples after 16 ticks; frm_err_bit = ~sample; issues push; → IDLE.
- Only the first stop bit is checked. A line held low after a framing error restarts START detection (break reads as repeated 0x00 frames with frm_err=1).
- FIFO:
  - Entry = {par_err_bit, frm_err_bit, data}.
  - First-word-fall-through: head entry appears on rx_data/frm_err/par_err whenever rx_data_rdy=1.
  - read_en while not empty pops the head; fifo_count decrements.
- Push while full and no read_en same cycle: character dropped and lost_data←1.
- Push while full with read_en same cycle: accepted; fifo_count unchanged.
- Push and pop while non-empty, not full: fifo_count unchanged.
- lost_data stays set until clear_lost=1. If clear_lost and a new loss coincide, lost_data remains 1 (set wins).
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from fifo_count.

## Timing
- Synchroniser latency: 2 clk_rx from rxd_i to rxd_clk_rx.
- Bit sampling is nominally mid-bit: 8 ticks after the start edge, then every 16 ticks.
- Push occurs in the clk_rx cycle after the stop-sample tick. rx_data_rdy and fifo_count update on the following edge.
- Falling edge to rx_data_rdy, 8N1 at DIV=27: 9.5 bit times + ≤4 clk_rx.
- rst_clk_rx_n low forces all state to reset values immediately, regardless of a frame in progress or FIFO contents. Release is synchronised internally (2-flop reset bridge, deassert on clk_rx edge).
- A partial frame interrupted by reset is discarded; reception resumes at the next falling edge after release.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY selects none/even/odd.
  - The PARITY state and the par_err FIFO bit are implemented.
- UART_RX_PARITY_EN undefined:
  - PARITY is ignored and the frame is always DATA_BITS N 1.
  - No PARITY state; FIFO width is DATA_BITS+1; par_err tied 0.

## Test plan
- 8N1, DIV=27, send 0xA5 → rx_data=0xA5, frm_err=0, par_err=0, fifo_count=1; read_en 1 cycle → rx_data_rdy=0, fifo_count=0.
- rxd_i low for 4 baud ticks (≈108 clk_rx), then high → stays in IDLE, no entry, fifo_count=0.
- Send 0x3C with stop bit 0 → entry data 0x3C, frm_err=1; next normal frame 0x55 → second entry frm_err=0.
- FIFO_DEPTH=4, send 0x01..0x05, no reads → fifo_count=4, lost_data=1, pops return 0x01..0x04. Pulse clear_lost → lost_data=0. Push and pop in the same cycle while full → count stays 4, no loss.
- UART_RX_PARITY_EN, PARITY=1, DATA_BITS=7: send 0x01 with parity bit 0 → par_err=1; with parity bit 1 → par_err=0.
- Assert rst_clk_rx_n mid-DATA with 2 entries queued → outputs reset within the same cycle, fifo_count=0; after release, 0x7E is received correctly.
